// File: rtl/int_arb_pkg.sv
// Shared types and constants for the interrupt arbiter.
package int_arb_pkg;

    // Sequencer states: arbitrate, hold request, settle after acknowledge.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StAck  = 2'd2
    } int_arb_state_e;

    // Field widths of the core's interrupt request fields.
    localparam int unsigned PrioW  = 4;
    localparam int unsigned LevelW = 5;
    localparam int unsigned VecW   = 8;
    localparam int unsigned IdxW   = 4;

    // NMI is presented above every maskable level.
    localparam logic [LevelW-1:0] NmiLevel = 5'h1F;

    // Vector of maskable source idx, 8-bit wrap.
    function automatic logic [VecW-1:0] src_vec(input logic [VecW-1:0] base,
                                                input logic [IdxW-1:0] idx);
        return base + VecW'(idx);
    endfunction

endpackage

// File: rtl/int_arb_if.sv
// Bus between the interrupt arbiter and the core / register file / sources.
interface int_arb_if #(
    parameter int unsigned NSRC = 8
);
    import int_arb_pkg::*;

    logic [NSRC-1:0]   irq;
    logic              nmi;
    logic [PrioW-1:0]  sr_i;
    logic              inta_ack;
    logic              cfg_we;
    logic [IdxW-1:0]   cfg_idx;
    logic [PrioW-1:0]  cfg_lvl;
    logic              intr_req;
    logic [LevelW-1:0] intr_level;
    logic [VecW-1:0]   intr_vec;
    logic [NSRC-1:0]   pending;

    // Core side: drives sources, mask, acknowledge and configuration.
    modport master (
        output irq, nmi, sr_i, inta_ack, cfg_we, cfg_idx, cfg_lvl,
        input  intr_req, intr_level, intr_vec, pending
    );

    // Arbiter side.
    modport slave (
        input  irq, nmi, sr_i, inta_ack, cfg_we, cfg_idx, cfg_lvl,
        output intr_req, intr_level, intr_vec, pending
    );

endinterface

// File: rtl/int_prio_enc.sv
// NSRC-way max-priority encoder; ties resolve to the lowest index.
module int_prio_enc
    import int_arb_pkg::*;
#(
    parameter int unsigned NSRC = 8
) (
    input  logic [NSRC-1:0]            cand,
    input  logic [NSRC-1:0][PrioW-1:0] prio,
    output logic                       valid,
    output logic [IdxW-1:0]            idx,
    output logic [PrioW-1:0]           lvl
);

    // Ascending scan with strict compare keeps the lowest index on a tie.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        lvl   = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (cand[k] && (!valid || (prio[k] > lvl))) begin
                valid = 1'b1;
                idx   = IdxW'(k);
                lvl   = prio[k];
            end
        end
    end

endmodule

// File: rtl/int_arb.sv
// Interrupt arbiter/sequencer in front of the CPU core.
// Optional macro INT_ARB_EDGE_TRIG_EN: maskable sources become rising-edge
// latched and are cleared by their own acknowledge (default: level mode).
module int_arb
    import int_arb_pkg::*;
#(
    parameter int unsigned     NSRC     = 8,
    parameter logic [VecW-1:0] VEC_BASE = 8'h40,
    parameter logic [VecW-1:0] NMI_VEC  = 8'h0B
) (
    input logic     clk,
    input logic     rst,
    int_arb_if.slave bus
);

    logic [NSRC-1:0][PrioW-1:0] prio_q;
    logic [NSRC-1:0]            pending_q, pending_d;
    logic                       nmi_prev_q, nmi_pend_q, nmi_pend_d;
    logic                       nmi_rise, nmi_clr, cfg_hit;

    int_arb_state_e             state_q, state_d;
    logic                       req_q, req_d;
    logic [LevelW-1:0]          level_q, level_d;
    logic [VecW-1:0]            vec_q, vec_d;
    logic [IdxW-1:0]            win_idx_q, win_idx_d;
    logic                       win_nmi_q, win_nmi_d;

    logic [NSRC-1:0]            cand;
    logic                       enc_valid;
    logic [IdxW-1:0]            enc_idx;
    logic [PrioW-1:0]           enc_prio;
    logic [PrioW-1:0]           win_prio;
    logic                       withdraw;

    assign cfg_hit = bus.cfg_we && ({1'b0, bus.cfg_idx} < 5'(NSRC));

    // Priority registers; out-of-range indices are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            for (int k = 0; k < NSRC; k++) begin
                if (cfg_hit && (bus.cfg_idx == IdxW'(k))) prio_q[k] <= bus.cfg_lvl;
            end
        end
    end

`ifdef INT_ARB_EDGE_TRIG_EN
    logic [NSRC-1:0] irq_prev_q, src_clr;

    // Clear of the acked source; a fresh edge in the same cycle wins.
    always_comb begin
        src_clr = '0;
        for (int k = 0; k < NSRC; k++) begin
            src_clr[k] = (state_q == StAck) && !win_nmi_q && (win_idx_q == IdxW'(k));
        end
        pending_d = (pending_q & ~src_clr) | (bus.irq & ~irq_prev_q);
    end

    // Edge history of the maskable lines.
    always_ff @(posedge clk) begin
        if (rst) irq_prev_q <= '0;
        else     irq_prev_q <= bus.irq;
    end
`else
    assign pending_d = bus.irq;
`endif

    assign nmi_rise   = bus.nmi && !nmi_prev_q;
    assign nmi_clr    = (state_q == StReq) && bus.inta_ack && win_nmi_q;
    assign nmi_pend_d = nmi_rise || (nmi_pend_q && !nmi_clr);

    // Pending status and NMI latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            nmi_prev_q <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            nmi_prev_q <= bus.nmi;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // Candidate set against the current mask.
    always_comb begin
        cand = '0;
        for (int k = 0; k < NSRC; k++) cand[k] = pending_q[k] && (prio_q[k] > bus.sr_i);
    end

    int_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .cand  (cand),
        .prio  (prio_q),
        .valid (enc_valid),
        .idx   (enc_idx),
        .lvl   (enc_prio)
    );

`ifdef INT_ARB_EDGE_TRIG_EN
    // Frozen winner is withdrawn only when masked off by a prio/SR.I change.
    always_comb begin
        win_prio = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (win_idx_q == IdxW'(k)) win_prio = prio_q[k];
        end
        withdraw = !win_nmi_q && (win_prio <= bus.sr_i);
    end
`else
    logic win_pend;

    // Frozen winner is withdrawn when its line drops or it gets masked off.
    always_comb begin
        win_prio = '0;
        win_pend = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (win_idx_q == IdxW'(k)) begin
                win_prio = prio_q[k];
                win_pend = pending_q[k];
            end
        end
        withdraw = !win_nmi_q && (!win_pend || (win_prio <= bus.sr_i));
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state; acknowledge takes precedence over withdraw.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (nmi_pend_q || enc_valid) state_d = StReq;
            StReq: begin
                if (bus.inta_ack)  state_d = StAck;
                else if (withdraw) state_d = StIdle;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: capture the winner in IDLE, freeze it until ack/withdraw.
    always_comb begin
        req_d     = req_q;
        level_d   = level_q;
        vec_d     = vec_q;
        win_idx_d = win_idx_q;
        win_nmi_d = win_nmi_q;
        unique case (state_q)
            StIdle: begin
                if (nmi_pend_q) begin
                    req_d     = 1'b1;
                    level_d   = NmiLevel;
                    vec_d     = NMI_VEC;
                    win_idx_d = '0;
                    win_nmi_d = 1'b1;
                end else if (enc_valid) begin
                    req_d     = 1'b1;
                    level_d   = {1'b0, enc_prio};
                    vec_d     = src_vec(VEC_BASE, enc_idx);
                    win_idx_d = enc_idx;
                    win_nmi_d = 1'b0;
                end
            end
            StReq:   if (bus.inta_ack || withdraw) req_d = 1'b0;
            StAck:   req_d = 1'b0;
            default: req_d = 1'b0;
        endcase
    end

    // Registered request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= 1'b0;
            level_q   <= '0;
            vec_q     <= '0;
            win_idx_q <= '0;
            win_nmi_q <= 1'b0;
        end else begin
            req_q     <= req_d;
            level_q   <= level_d;
            vec_q     <= vec_d;
            win_idx_q <= win_idx_d;
            win_nmi_q <= win_nmi_d;
        end
    end

    assign bus.intr_req   = req_q;
    assign bus.intr_level = level_q;
    assign bus.intr_vec   = vec_q;
    assign bus.pending    = pending_q;

endmodule
